// File: rtl/csr_trap_ctrl_if.sv
// Memory-stage trap/return interface: pipeline event inputs, CSR snapshot,
// CSR write port and redirect outputs of the trap sequencer.
interface csr_trap_ctrl_if #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned ECODE_W = 6
);
   localparam int unsigned CSR_AW = 12;

   logic               stall_m;
   logic               instr_valid;
   logic [XLEN-1:0]    instr_pc;
   logic               exc_valid;
   logic [ECODE_W-1:0] exc_code;
   logic [XLEN-1:0]    exc_tval;
   logic               is_mret;
   logic               trint;
   logic               swint;
   logic               exint;
   logic [XLEN-1:0]    mstatus;
   logic [XLEN-1:0]    mie;
   logic [XLEN-1:0]    mtvec;
   logic [XLEN-1:0]    mepc;

   logic [XLEN-1:0]    mip_val;
   logic               kill_m;
   logic               busy;
   logic               csr_we;
   logic [CSR_AW-1:0]  csr_waddr;
   logic [XLEN-1:0]    csr_wdata;
   logic               redirect_valid;
   logic [XLEN-1:0]    redirect_pc;
   logic               flushall;

   modport master (
      output stall_m, instr_valid, instr_pc, exc_valid, exc_code, exc_tval,
             is_mret, trint, swint, exint, mstatus, mie, mtvec, mepc,
      input  mip_val, kill_m, busy, csr_we, csr_waddr, csr_wdata,
             redirect_valid, redirect_pc, flushall
   );

   modport slave (
      input  stall_m, instr_valid, instr_pc, exc_valid, exc_code, exc_tval,
             is_mret, trint, swint, exint, mstatus, mie, mtvec, mepc,
      output mip_val, kill_m, busy, csr_we, csr_waddr, csr_wdata,
             redirect_valid, redirect_pc, flushall
   );
endinterface

// File: rtl/csr_trap_ctrl.sv
// M-mode trap/mret sequencer: prioritises memory-stage events, writes
// mepc/mcause/mtval/mstatus one per cycle, then pulses a redirect with flush.
module csr_trap_ctrl #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned ECODE_W = 6
) (
   input logic           clk,
   input logic           reset,
   csr_trap_ctrl_if.slave bus
);
   localparam int unsigned CSR_AW = 12;
   localparam int unsigned IRQ_W  = 4;

   localparam logic [CSR_AW-1:0] A_MSTATUS = 12'h300;
   localparam logic [CSR_AW-1:0] A_MEPC    = 12'h341;
   localparam logic [CSR_AW-1:0] A_MCAUSE  = 12'h342;
   localparam logic [CSR_AW-1:0] A_MTVAL   = 12'h343;

   localparam logic [IRQ_W-1:0] IRQ_MSI = 4'd3;
   localparam logic [IRQ_W-1:0] IRQ_MTI = 4'd7;
   localparam logic [IRQ_W-1:0] IRQ_MEI = 4'd11;

   typedef enum logic [2:0] {
      IDLE,
      W_EPC,
      W_CAUSE,
      W_TVAL,
      W_STAT,
      REDIR
   } state_e;

   state_e state_q, state_d;

   logic [XLEN-1:0]   epc_q, epc_d;
   logic [XLEN-1:0]   cause_q, cause_d;
   logic [XLEN-1:0]   tval_q, tval_d;
   logic [XLEN-1:0]   stat_q, stat_d;
   logic [XLEN-1:0]   target_q, target_d;

   logic              csr_we_q, csr_we_d;
   logic [CSR_AW-1:0] csr_waddr_q, csr_waddr_d;
   logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
   logic              redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

   logic [XLEN-1:0]   mip_c;
   logic [XLEN-1:0]   pend_c;
   logic              irq_take_c;
   logic [IRQ_W-1:0]  irq_no_c;
   logic              accept_c;
   logic [XLEN-1:0]   trap_stat_c;
   logic [XLEN-1:0]   mret_stat_c;
   logic [XLEN-1:0]   tvec_base_c;

   // Pending-interrupt view and priority select (MEI > MSI > MTI)
   always_comb begin
      mip_c     = '0;
      mip_c[3]  = bus.swint;
      mip_c[7]  = bus.trint;
      mip_c[11] = bus.exint;
      pend_c    = bus.mie & mip_c;
      irq_take_c = bus.mstatus[3] & (|pend_c);
      if (pend_c[11])     irq_no_c = IRQ_MEI;
      else if (pend_c[3]) irq_no_c = IRQ_MSI;
      else                irq_no_c = IRQ_MTI;
   end

   assign accept_c = (state_q == IDLE) & bus.instr_valid & ~bus.stall_m &
                     (bus.exc_valid | irq_take_c | bus.is_mret);

   // mstatus images for trap entry and mret
   always_comb begin
      trap_stat_c        = bus.mstatus;
      trap_stat_c[3]     = 1'b0;
      trap_stat_c[7]     = bus.mstatus[3];
      trap_stat_c[12:11] = 2'b11;
      mret_stat_c        = bus.mstatus;
      mret_stat_c[3]     = bus.mstatus[7];
      mret_stat_c[7]     = 1'b1;
      mret_stat_c[12:11] = 2'b11;
      tvec_base_c        = {bus.mtvec[XLEN-1:2], 2'b00};
   end

   // Next state, latched trap context and registered write/redirect outputs
   always_comb begin
      state_d          = state_q;
      epc_d            = epc_q;
      cause_d          = cause_q;
      tval_d           = tval_q;
      stat_d           = stat_q;
      target_d         = target_q;
      csr_we_d         = 1'b0;
      csr_waddr_d      = '0;
      csr_wdata_d      = '0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = '0;

      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               epc_d = bus.instr_pc;
               if (bus.exc_valid) begin
                  cause_d  = XLEN'(bus.exc_code);
                  tval_d   = bus.exc_tval;
                  stat_d   = trap_stat_c;
                  target_d = tvec_base_c;
                  state_d  = W_EPC;
               end else if (irq_take_c) begin
                  cause_d  = (XLEN'(1) << (XLEN-1)) | XLEN'(irq_no_c);
                  tval_d   = '0;
                  stat_d   = trap_stat_c;
                  target_d = (bus.mtvec[1:0] == 2'b01)
                           ? tvec_base_c + XLEN'({irq_no_c, 2'b00})
                           : tvec_base_c;
                  state_d  = W_EPC;
               end else begin
                  stat_d   = mret_stat_c;
                  target_d = bus.mepc;
                  state_d  = W_STAT;
               end
            end
         end
         W_EPC:   state_d = W_CAUSE;
         W_CAUSE: state_d = W_TVAL;
         W_TVAL:  state_d = W_STAT;
         W_STAT:  state_d = REDIR;
         REDIR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs follow the state being entered so they appear in that state's cycle
      unique case (state_d)
         W_EPC: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = A_MEPC;
            csr_wdata_d = epc_d;
         end
         W_CAUSE: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = A_MCAUSE;
            csr_wdata_d = cause_d;
         end
         W_TVAL: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = A_MTVAL;
            csr_wdata_d = tval_d;
         end
         W_STAT: begin
            csr_we_d    = 1'b1;
            csr_waddr_d = A_MSTATUS;
            csr_wdata_d = stat_d;
         end
         REDIR: begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         epc_q            <= '0;
         cause_q          <= '0;
         tval_q           <= '0;
         stat_q           <= '0;
         target_q         <= '0;
         csr_we_q         <= 1'b0;
         csr_waddr_q      <= '0;
         csr_wdata_q      <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         epc_q            <= epc_d;
         cause_q          <= cause_d;
         tval_q           <= tval_d;
         stat_q           <= stat_d;
         target_q         <= target_d;
         csr_we_q         <= csr_we_d;
         csr_waddr_q      <= csr_waddr_d;
         csr_wdata_q      <= csr_wdata_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign bus.mip_val        = mip_c;
   assign bus.kill_m         = accept_c;
   assign bus.busy           = (state_q != IDLE) | accept_c;
   assign bus.csr_we         = csr_we_q;
   assign bus.csr_waddr      = csr_waddr_q;
   assign bus.csr_wdata      = csr_wdata_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.flushall       = redirect_valid_q;
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: trap, vectored irq, mret, priority,
// stall gating, MIE masking and reset mid-sequence.
module tb_csr_trap_ctrl;
   localparam int unsigned XLEN    = 64;
   localparam int unsigned ECODE_W = 6;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   csr_trap_ctrl_if #(.XLEN(XLEN), .ECODE_W(ECODE_W)) bus ();

   csr_trap_ctrl #(.XLEN(XLEN), .ECODE_W(ECODE_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      bus.instr_valid = 1'b0;
      bus.exc_valid   = 1'b0;
      bus.is_mret     = 1'b0;
      bus.trint       = 1'b0;
      bus.swint       = 1'b0;
      bus.exint       = 1'b0;
      bus.stall_m     = 1'b0;
   endtask

   task automatic chk_write(input string tag, input logic [11:0] addr, input logic [63:0] data);
      chk({tag, "_we"}, 64'(bus.csr_we), 64'd1);
      chk({tag, "_addr"}, 64'(bus.csr_waddr), 64'(addr));
      chk({tag, "_data"}, bus.csr_wdata, data);
      chk({tag, "_rv"}, 64'(bus.redirect_valid), 64'd0);
   endtask

   // Called in the accept cycle T, after that cycle's inputs are applied
   task automatic trap_seq(input string tag, input logic [63:0] epc, input logic [63:0] cause,
                           input logic [63:0] tval, input logic [63:0] stat,
                           input logic [63:0] target);
      chk({tag, "_kill"}, 64'(bus.kill_m), 64'd1);
      chk({tag, "_busyT"}, 64'(bus.busy), 64'd1);
      tick();
      clear_events();
      bus.mie = '0;
      chk_write({tag, "_mepc"}, 12'h341, epc);
      tick();
      chk_write({tag, "_mcause"}, 12'h342, cause);
      // New events and CSR changes while busy must be ignored
      bus.instr_valid = 1'b1;
      bus.exc_valid   = 1'b1;
      bus.is_mret     = 1'b1;
      bus.instr_pc    = 64'hBAD0;
      bus.mtvec       = 64'hBAD00;
      bus.mstatus     = 64'h0;
      #1;
      chk({tag, "_killbusy"}, 64'(bus.kill_m), 64'd0);
      tick();
      clear_events();
      chk_write({tag, "_mtval"}, 12'h343, tval);
      tick();
      chk_write({tag, "_mstatus"}, 12'h300, stat);
      tick();
      chk({tag, "_redir"}, 64'(bus.redirect_valid), 64'd1);
      chk({tag, "_flush"}, 64'(bus.flushall), 64'd1);
      chk({tag, "_rpc"}, bus.redirect_pc, target);
      chk({tag, "_we_redir"}, 64'(bus.csr_we), 64'd0);
      chk({tag, "_busy_redir"}, 64'(bus.busy), 64'd1);
      tick();
      chk({tag, "_redir_end"}, 64'(bus.redirect_valid), 64'd0);
      chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
      chk({tag, "_waddr_end"}, 64'(bus.csr_waddr), 64'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      clear_events();
      bus.instr_pc = '0;
      bus.exc_code = '0;
      bus.exc_tval = '0;
      bus.mstatus  = '0;
      bus.mie      = '0;
      bus.mtvec    = '0;
      bus.mepc     = '0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_we", 64'(bus.csr_we), 64'd0);
      chk("rst_waddr", 64'(bus.csr_waddr), 64'd0);
      chk("rst_wdata", bus.csr_wdata, 64'd0);
      chk("rst_rv", 64'(bus.redirect_valid), 64'd0);
      chk("rst_flush", 64'(bus.flushall), 64'd0);
      chk("rst_rpc", bus.redirect_pc, 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_kill", 64'(bus.kill_m), 64'd0);

      // 1: ecall
      tick();
      bus.mtvec = 64'h8000_1000; bus.mstatus = 64'h8; bus.mie = '0;
      bus.instr_valid = 1'b1; bus.instr_pc = 64'h8000_0010;
      bus.exc_valid = 1'b1; bus.exc_code = 6'd11; bus.exc_tval = '0;
      #1;
      trap_seq("ecall", 64'h8000_0010, 64'd11, 64'd0, 64'h1880, 64'h8000_1000);

      // 2: vectored timer interrupt
      bus.mtvec = 64'h8000_1001; bus.mstatus = 64'h8; bus.mie = 64'h80;
      bus.trint = 1'b1; bus.instr_valid = 1'b1; bus.instr_pc = 64'h8000_0100;
      #1;
      chk("tirq_mip", bus.mip_val, 64'h80);
      trap_seq("tirq", 64'h8000_0100, 64'h8000_0000_0000_0007, 64'd0, 64'h1880, 64'h8000_101C);

      // 3: mret
      bus.mstatus = 64'h1880; bus.mepc = 64'h8000_0200; bus.mtvec = 64'h8000_1000;
      bus.is_mret = 1'b1; bus.instr_valid = 1'b1; bus.instr_pc = 64'h8000_0050;
      #1;
      chk("mret_kill", 64'(bus.kill_m), 64'd1);
      chk("mret_busyT", 64'(bus.busy), 64'd1);
      tick();
      clear_events();
      bus.mepc = 64'h1234;
      chk_write("mret_mstatus", 12'h300, 64'h1888);
      tick();
      chk("mret_redir", 64'(bus.redirect_valid), 64'd1);
      chk("mret_flush", 64'(bus.flushall), 64'd1);
      chk("mret_rpc", bus.redirect_pc, 64'h8000_0200);
      chk("mret_we", 64'(bus.csr_we), 64'd0);
      tick();
      chk("mret_redir_end", 64'(bus.redirect_valid), 64'd0);
      chk("mret_busy_end", 64'(bus.busy), 64'd0);

      // 4: exception beats interrupts and mret; then MEI beats MSI
      bus.mstatus = 64'h8; bus.mie = 64'h888; bus.mtvec = 64'h8000_1000;
      bus.exint = 1'b1; bus.swint = 1'b1; bus.is_mret = 1'b1;
      bus.exc_valid = 1'b1; bus.exc_code = 6'd2; bus.exc_tval = 64'hDEAD;
      bus.instr_valid = 1'b1; bus.instr_pc = 64'h8000_0300;
      #1;
      chk("prio_mip", bus.mip_val, 64'h808);
      trap_seq("prio_exc", 64'h8000_0300, 64'd2, 64'hDEAD, 64'h1880, 64'h8000_1000);
      bus.mstatus = 64'h8; bus.mie = 64'h888; bus.mtvec = 64'h8000_1000;
      bus.exint = 1'b1; bus.swint = 1'b1;
      bus.instr_valid = 1'b1; bus.instr_pc = 64'h8000_0304;
      #1;
      trap_seq("prio_mei", 64'h8000_0304, 64'h8000_0000_0000_000B, 64'd0, 64'h1880, 64'h8000_1000);

      // 5: stall blocks accept for three cycles
      bus.mstatus = 64'h8; bus.mie = 64'h8; bus.mtvec = 64'h8000_1000;
      bus.swint = 1'b1; bus.stall_m = 1'b1;
      bus.instr_valid = 1'b1; bus.instr_pc = 64'h8000_0400;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_kill", 64'(bus.kill_m), 64'd0);
         chk("stall_busy", 64'(bus.busy), 64'd0);
         tick();
         chk("stall_we", 64'(bus.csr_we), 64'd0);
      end
      bus.stall_m = 1'b0;
      #1;
      trap_seq("stall_msi", 64'h8000_0400, 64'h8000_0000_0000_0003, 64'd0, 64'h1880, 64'h8000_1000);

      // MIE=0 masks interrupts but not exceptions
      bus.mstatus = 64'h0; bus.mie = 64'h888; bus.mtvec = 64'h8000_2000;
      bus.swint = 1'b1; bus.instr_valid = 1'b1; bus.instr_pc = 64'h8000_0500;
      #1;
      chk("mie0_kill", 64'(bus.kill_m), 64'd0);
      chk("mie0_busy", 64'(bus.busy), 64'd0);
      tick();
      chk("mie0_we", 64'(bus.csr_we), 64'd0);
      bus.exc_valid = 1'b1; bus.exc_code = 6'd4; bus.exc_tval = 64'h77;
      #1;
      trap_seq("mie0_exc", 64'h8000_0500, 64'd4, 64'h77, 64'h1800, 64'h8000_2000);

      // 6: reset in the middle of a trap sequence
      bus.mstatus = 64'h8; bus.mtvec = 64'h8000_1000;
      bus.exc_valid = 1'b1; bus.exc_code = 6'd2; bus.exc_tval = 64'h5;
      bus.instr_valid = 1'b1; bus.instr_pc = 64'h8000_0600;
      #1;
      chk("rmid_kill", 64'(bus.kill_m), 64'd1);
      tick();
      clear_events();
      chk_write("rmid_mepc", 12'h341, 64'h8000_0600);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rmid_we", 64'(bus.csr_we), 64'd0);
      chk("rmid_waddr", 64'(bus.csr_waddr), 64'd0);
      chk("rmid_wdata", bus.csr_wdata, 64'd0);
      chk("rmid_busy", 64'(bus.busy), 64'd0);
      chk("rmid_rpc", bus.redirect_pc, 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rmid_after_we", 64'(bus.csr_we), 64'd0);
         chk("rmid_after_rv", 64'(bus.redirect_valid), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
